// File: rtl/comparador_serie.sv
// Serial MSB-first comparator: one bit pair per accepted cycle, registered result plus a done pulse.
// Define COMPARADOR_MAGNITUD_EN to add unsigned a>b / a<b tracking; otherwise agtb/altb stay 0.
module comparador_serie #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic aeqb,
    output logic agtb,
    output logic altb
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMP,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          eq_q, eq_d;
    logic          aeqb_q, aeqb_d;
`ifdef COMPARADOR_MAGNITUD_EN
    logic          gt_q, gt_d;
    logic          lt_q, lt_d;
    logic          agtb_q, agtb_d;
    logic          altb_q, altb_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        aeqb_d  = aeqb_q;
`ifdef COMPARADOR_MAGNITUD_EN
        gt_d    = gt_q;
        lt_d    = lt_q;
        agtb_d  = agtb_q;
        altb_d  = altb_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COMP;
                    cnt_d   = '0;
                    eq_d    = 1'b1;
                    aeqb_d  = 1'b0;
`ifdef COMPARADOR_MAGNITUD_EN
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    agtb_d  = 1'b0;
                    altb_d  = 1'b0;
`endif
                end
            end
            COMP: begin
                if (bit_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    // The first differing bit decides; later bits are only counted.
                    if (eq_q && (a_bit != b_bit)) begin
                        eq_d = 1'b0;
`ifdef COMPARADOR_MAGNITUD_EN
                        gt_d = a_bit & ~b_bit;
                        lt_d = ~a_bit & b_bit;
`endif
                    end
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        aeqb_d  = eq_d;
`ifdef COMPARADOR_MAGNITUD_EN
                        agtb_d  = gt_d;
                        altb_d  = lt_d;
`endif
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            aeqb_q  <= 1'b0;
`ifdef COMPARADOR_MAGNITUD_EN
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            agtb_q  <= 1'b0;
            altb_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
            aeqb_q  <= aeqb_d;
`ifdef COMPARADOR_MAGNITUD_EN
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            agtb_q  <= agtb_d;
            altb_q  <= altb_d;
`endif
        end
    end

    assign busy = (state_q == COMP);
    assign done = (state_q == DONE);
    assign aeqb = aeqb_q;
`ifdef COMPARADOR_MAGNITUD_EN
    assign agtb = agtb_q;
    assign altb = altb_q;
`else
    assign agtb = 1'b0;
    assign altb = 1'b0;
`endif

endmodule

// File: tb/tb_comparador_serie.sv
// Randomized bench for comparador_serie (N=4) against an integer-compare reference model.
module tb_comparador_serie;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic bit_valid = 1'b0;
    logic a_bit = 1'b0;
    logic b_bit = 1'b0;
    logic busy, done, aeqb, agtb, altb;

    int n_checks = 0;
    int n_fail   = 0;

    logic exp_eq, exp_gt, exp_lt;

    comparador_serie #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .busy      (busy),
        .done      (done),
        .aeqb      (aeqb),
        .agtb      (agtb),
        .altb      (altb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain unsigned integer comparison of the whole operands.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_eq = (a == b);
`ifdef COMPARADOR_MAGNITUD_EN
        exp_gt = (a > b);
        exp_lt = (a < b);
`else
        exp_gt = 1'b0;
        exp_lt = 1'b0;
`endif
    endtask

    task automatic check_results(input string tag, input logic e, input logic g, input logic l);
        check({tag, "_aeqb"}, aeqb, e);
        check({tag, "_agtb"}, agtb, g);
        check({tag, "_altb"}, altb, l);
    endtask

    // One full comparison. gap_pct: chance of a bit_valid=0 cycle before each bit.
    // noise: pulse start randomly while busy and in the DONE cycle (must be ignored).
    task automatic run_cmp(input logic [N-1:0] a, input logic [N-1:0] b,
                           input int gap_pct, input bit noise);
        logic pe, pg, pl;
        pe = aeqb; pg = agtb; pl = altb;
        model(a, b);
        // Inputs drive at negedge; the DUT samples them at the following posedge.
        start = 1'b1;
        bit_valid = 1'($urandom_range(0, 1));
        a_bit = 1'($urandom_range(0, 1));
        b_bit = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("done_after_start", done, 1'b0);
        check_results("cleared_after_start", 1'b0, 1'b0, 1'b0);
        for (int i = N - 1; i >= 0; i--) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                bit_valid = 1'b0;
                a_bit = 1'($urandom_range(0, 1));
                b_bit = 1'($urandom_range(0, 1));
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
                check("busy_in_gap", busy, 1'b1);
                check("done_in_gap", done, 1'b0);
            end
            bit_valid = 1'b1;
            a_bit = a[i];
            b_bit = b[i];
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (i != 0) begin
                check("busy_mid", busy, 1'b1);
                check("done_mid", done, 1'b0);
            end
        end
        check("done_pulse", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check_results("result", exp_eq, exp_gt, exp_lt);
        check("one_hot", 1'(aeqb + agtb + altb == 2'd1)
`ifdef COMPARADOR_MAGNITUD_EN
              , 1'b1);
`else
              , exp_eq);
`endif
        bit_valid = 1'($urandom_range(0, 1));
        a_bit = 1'($urandom_range(0, 1));
        b_bit = 1'($urandom_range(0, 1));
        start = noise ? 1'b1 : 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
        check_results("hold", exp_eq, exp_gt, exp_lt);
        if (pe === 1'bx || pg === 1'bx || pl === 1'bx) n_checks = n_checks;
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check_results("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Directed cases from the test plan.
        run_cmp(4'b1011, 4'b1011, 0, 1'b0);
        run_cmp(4'b1000, 4'b0111, 0, 1'b0);
        run_cmp(4'b0011, 4'b0101, 0, 1'b0);
        run_cmp(4'b0110, 4'b0110, 0, 1'b0);

        // Gaps: two idle bit_valid cycles after bit 1, done must be delayed by exactly two.
        model(4'b1100, 4'b1100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            bit_valid = 1'b1;
            a_bit = 1'b1 & (i >= 2);
            b_bit = 1'b1 & (i >= 2);
            @(negedge clk);
            if (i == N - 1) begin
                bit_valid = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    check("gap_busy", busy, 1'b1);
                end
            end
            if (i != 0) check("gap_done_early", done, 1'b0);
        end
        bit_valid = 1'b0;
        check("gap_done", done, 1'b1);
        check_results("gap", exp_eq, exp_gt, exp_lt);
        @(negedge clk);

        // Reset after two bits aborts with no done pulse.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_valid = 1'b1;
            a_bit = 1'b1;
            b_bit = 1'b0;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check_results("abort", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (N + 2) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
            check("abort_idle", busy, 1'b0);
        end
        bit_valid = 1'b0;
        run_cmp(4'b0101, 4'b0100, 0, 1'b1);

        // Randomized comparisons with gaps, ignored start pulses and occasional resets.
        for (int t = 0; t < 80; t++) begin
            logic [N-1:0] ra, rb;
            ra = N'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : N'($urandom);
            run_cmp(ra, rb, 25, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_results("rand_rst", 1'b0, 1'b0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
